// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Multi-cycle restoring unsigned divider, 2N-bit dividend by
//               N-bit divisor, one quotient bit per clock, MSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int N = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   quot,
    output logic [N-1:0]     rem,
    output logic             dz
);

    localparam int CW = (2 * N > 1) ? $clog2(2 * N) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(2 * N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [2*N-1:0]   r_dvd;
    logic [2*N-1:0]   r_q;
    logic [N-1:0]     r_dsr;
    logic [N:0]       r_pr;
    logic [CW-1:0]    r_cnt;

    logic [N:0]       w_pr_sh;
    logic             w_ge;
    logic [N:0]       w_pr_nx;
    logic [2*N-1:0]   w_q_nx;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign w_pr_sh = {r_pr[N-1:0], r_dvd[2*N-1]};
    assign w_ge    = (w_pr_sh >= {1'b0, r_dsr});
    assign w_pr_nx = w_ge ? (w_pr_sh - {1'b0, r_dsr}) : w_pr_sh;
    assign w_q_nx  = {r_q[2*N-2:0], w_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_dvd   <= '0;
            r_q     <= '0;
            r_dsr   <= '0;
            r_pr    <= '0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            quot    <= '0;
            rem     <= '0;
            dz      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_dvd   <= dividend;
                        r_dsr   <= divisor;
                        r_pr    <= '0;
                        r_q     <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_pr  <= w_pr_nx;
                    r_dvd <= {r_dvd[2*N-2:0], 1'b0};
                    r_q   <= w_q_nx;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == C_LAST) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                        // A zero divisor still runs the full schedule; only the result is replaced.
                        if (r_dsr == '0) begin
                            quot <= '1;
                            rem  <= '0;
                            dz   <= 1'b1;
                        end else begin
                            quot <= w_q_nx;
                            rem  <= w_pr_nx[N-1:0];
                            dz   <= 1'b0;
                        end
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider (vectors, handshake
//               sequences, random and exhaustive operands vs. a model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int N = 3;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   quot;
    logic [N-1:0]     rem;
    logic             dz;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quot     (quot),
        .rem      (rem),
        .dz       (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] a;
        logic [2:0] b;
        logic [5:0] q;
        logic [2:0] r;
        logic       z;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer division, with the zero-divisor result rule.
    task automatic ref_div(input int a, input int b, output int q, output int r, output int z);
        if (b == 0) begin
            q = (1 << (2 * N)) - 1;
            r = 0;
            z = 1;
        end else begin
            q = a / b;
            r = a % b;
            z = 0;
        end
    endtask

    // Returns at the falling edge just after the accept edge.
    task automatic launch(input int a, input int b);
        @(negedge clk);
        dividend = a[2*N-1:0];
        divisor  = b[N-1:0];
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Counts edges from accept until done is seen (bounded).
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!done && lat < 30) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_check(input string tag, input int a, input int b);
        int lat, bcnt, q, r, z;
        launch(a, b);
        wait_done(lat, bcnt);
        ref_div(a, b, q, r, z);
        check({tag, " latency"}, lat, 6);
        check({tag, " quot"}, 32'(quot), q);
        check({tag, " rem"}, 32'(rem), r);
        check({tag, " dz"}, 32'(dz), z);
    endtask

    initial begin
        int lat, bcnt, q, r, z, a, b;
        logic saw_done;

        vecs[0] = '{6'd42, 3'd5, 6'd8,  3'd2, 1'b0};
        vecs[1] = '{6'd63, 3'd1, 6'd63, 3'd0, 1'b0};
        vecs[2] = '{6'd6,  3'd7, 6'd0,  3'd6, 1'b0};
        vecs[3] = '{6'd0,  3'd3, 6'd0,  3'd0, 1'b0};
        vecs[4] = '{6'd17, 3'd0, 6'd63, 3'd0, 1'b1};
        vecs[5] = '{6'd20, 3'd4, 6'd5,  3'd0, 1'b0};
        vecs[6] = '{6'd35, 3'd6, 6'd5,  3'd5, 1'b0};

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset quot", 32'(quot), 0);
        check("reset rem",  32'(rem),  0);
        check("reset dz",   32'(dz),   0);
        rst_n = 1'b1;

        // First division: busy window, done pulse, then held outputs.
        launch(42, 5);
        wait_done(lat, bcnt);
        check("42/5 latency", lat, 6);
        check("42/5 busy cycles", bcnt, 6);
        check("42/5 busy at done", 32'(busy), 0);
        check("42/5 quot", 32'(quot), 8);
        check("42/5 rem", 32'(rem), 2);
        check("42/5 dz", 32'(dz), 0);
        repeat (3) @(negedge clk);
        check("hold done low", 32'(done), 0);
        check("hold busy low", 32'(busy), 0);
        check("hold quot", 32'(quot), 8);
        check("hold rem", 32'(rem), 2);

        for (int i = 0; i < 7; i++) begin
            launch(vecs[i].a, vecs[i].b);
            wait_done(lat, bcnt);
            check($sformatf("vec%0d latency", i), lat, 6);
            check($sformatf("vec%0d quot", i), 32'(quot), 32'(vecs[i].q));
            check($sformatf("vec%0d rem", i), 32'(rem), 32'(vecs[i].r));
            check($sformatf("vec%0d dz", i), 32'(dz), 32'(vecs[i].z));
        end

        // Back-to-back: start in the DONE cycle.
        launch(42, 5);
        wait_done(lat, bcnt);
        dividend = 6'd35;
        divisor  = 3'd6;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        check("b2b busy after accept", 32'(busy), 1);
        check("b2b old quot held", 32'(quot), 8);
        wait_done(lat, bcnt);
        check("b2b latency", lat, 6);
        check("b2b quot", 32'(quot), 5);
        check("b2b rem", 32'(rem), 5);

        // start mid-RUN with other operands is ignored.
        launch(42, 5);
        @(negedge clk);
        dividend = 6'd63;
        divisor  = 3'd1;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        lat = 2;
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("midrun latency", lat, 6);
        check("midrun quot", 32'(quot), 8);
        check("midrun rem", 32'(rem), 2);
        @(negedge clk);
        check("midrun no restart", 32'(busy), 0);

        // Reset in the middle of an operation.
        launch(50, 3);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset busy", 32'(busy), 0);
        check("midreset done", 32'(done), 0);
        check("midreset quot", 32'(quot), 0);
        check("midreset rem", 32'(rem), 0);
        check("midreset dz", 32'(dz), 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check("midreset no done", 32'(saw_done), 0);
        run_check("50/3 after reset", 50, 3);

        for (int i = 0; i < 40; i++) begin
            run_check($sformatf("rand%0d", i), int'($urandom_range(0, 63)), int'($urandom_range(0, 7)));
        end

        // Exhaustive: quotient/remainder identity and model agreement.
        for (int ia = 0; ia < 64; ia++) begin
            for (int ib = 0; ib < 8; ib++) begin
                launch(ia, ib);
                wait_done(lat, bcnt);
                ref_div(ia, ib, q, r, z);
                a = int'(quot);
                b = int'(rem);
                if (lat != 6 || a != q || b != r || int'(dz) != z) begin
                    check($sformatf("exh %0d/%0d result", ia, ib),
                          {lat[7:0], 2'b0, quot, 5'b0, rem, 7'b0, dz}, {8'd6, 2'b0, 6'(q), 5'b0, 3'(r), 7'b0, 1'(z)});
                end else begin
                    n_checks++;
                end
                if (ib != 0) begin
                    if (a < 8)
                        check($sformatf("exh %0d/%0d product", ia, ib), a * ib + b, ia);
                    check($sformatf("exh %0d/%0d rem<div", ia, ib), 32'(b < ib), 1);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    always @(negedge clk) begin
        if (rst_n && busy && done) begin
            n_checks++;
            n_fail++;
            $display("FAIL busy_done_overlap: got busy=1 done=1 expected not both");
        end
    end

endmodule
`default_nettype wire
